four_bit_counter: RTL and testbench

Free-running synchronous up-counter, default 4 bits wide, with terminal-count and wrap-event status outputs. It sits as a basic sequencing and timebase element; downstream logic consumes `q` directly or uses `tc`/`wrap` to pace slower events. There are no handshakes and no enable: the counter advances on every clock edge while out of reset.

---
 rtl/four_bit_counter.sv | 52 +++++
 tb/tb_four_bit_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/four_bit_counter.sv
// four_bit_counter
//   Free-running synchronous up-counter with terminal-count and wrap-event
//   status. Advances on every rising clock edge while out of reset.
//
// Parameters
//   WIDTH      : counter width in bits (>= 2)
//   WRAP_CNT_W : width of the saturating wrap-event counter (>= 1)
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-low reset, has priority over counting
//   q        : current count (registered)
//   tc       : terminal count, high while q is all-ones (combinational from q)
//   wrap     : one-cycle registered pulse in the cycle q is 0 after a rollover
//   wrap_cnt : registered count of rollovers since reset, saturates at all-ones

`timescale 1ns/1ps

module four_bit_counter #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned WRAP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [WIDTH-1:0]      q,
   output logic                  tc,
   output logic                  wrap,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
);

   // Depends only on q, so it is 0 throughout a held reset.
   always_comb begin
      tc = (q == '1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q        <= '0;
         wrap     <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         q    <= q + 1'b1;
         // Registering tc gives a pulse exactly in the cycle after max,
         // i.e. when q has rolled to 0; a reset-driven 0 never raises it.
         wrap <= tc;
         if (tc && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_four_bit_counter.sv
`timescale 1ns/1ps

module tb_four_bit_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic [3:0] q4;
   logic       tc4;
   logic       wrap4;
   logic [7:0] wc4;

   logic [2:0] q3;
   logic       tc3;
   logic       wrap3;
   logic [7:0] wc3;

   int n_tests = 0;
   int n_fail  = 0;

   four_bit_counter #(.WIDTH(4), .WRAP_CNT_W(8)) dut4 (
      .clk(clk), .rst(rst), .q(q4), .tc(tc4), .wrap(wrap4), .wrap_cnt(wc4)
   );

   four_bit_counter #(.WIDTH(3), .WRAP_CNT_W(8)) dut3 (
      .clk(clk), .rst(rst), .q(q3), .tc(tc3), .wrap(wrap3), .wrap_cnt(wc3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      int q4; int tc4; int wrap4; int wc4;
      int q3; int tc3; int wrap3; int wc3;
   } exp_t;

   exp_t sb[$];

   // Reference model state (integer arithmetic, independent of RTL form)
   int mq4 = 0, mw4 = 0, mwc4 = 0;
   int mq3 = 0, mw3 = 0, mwc3 = 0;

   // Toggle tracking: index 0..3 q4, 4 tc4, 5 wrap4, 6 wc4[0], 7 rst
   bit seen0 [8];
   bit seen1 [8];

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic note(input int idx, input logic v);
      if (v === 1'b0) seen0[idx] = 1'b1;
      if (v === 1'b1) seen1[idx] = 1'b1;
   endtask

   // Drive one cycle: update model, push expectation, clock, pop and compare.
   task automatic step(input logic r);
      exp_t e;
      exp_t g;
      rst = r;
      note(7, r);
      if (!r) begin
         mq4 = 0; mw4 = 0; mwc4 = 0;
         mq3 = 0; mw3 = 0; mwc3 = 0;
      end else begin
         mw4 = (mq4 == 15) ? 1 : 0;
         if (mq4 == 15 && mwc4 < 255) mwc4 = mwc4 + 1;
         mq4 = (mq4 + 1) % 16;
         mw3 = (mq3 == 7) ? 1 : 0;
         if (mq3 == 7 && mwc3 < 255) mwc3 = mwc3 + 1;
         mq3 = (mq3 + 1) % 8;
      end
      e.q4 = mq4; e.tc4 = (mq4 == 15) ? 1 : 0; e.wrap4 = mw4; e.wc4 = mwc4;
      e.q3 = mq3; e.tc3 = (mq3 == 7)  ? 1 : 0; e.wrap3 = mw3; e.wc3 = mwc3;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("q4",    int'(q4),    g.q4);
      chk("tc4",   int'(tc4),   g.tc4);
      chk("wrap4", int'(wrap4), g.wrap4);
      chk("wc4",   int'(wc4),   g.wc4);
      chk("q3",    int'(q3),    g.q3);
      chk("tc3",   int'(tc3),   g.tc3);
      chk("wrap3", int'(wrap3), g.wrap3);
      chk("wc3",   int'(wc3),   g.wc3);
      for (int unsigned i = 0; i < 4; i++) note(int'(i), q4[i]);
      note(4, tc4);
      note(5, wrap4);
      note(6, wc4[0]);
   endtask

   int wrap_edges;

   initial begin
      // Reset for 2 edges
      step(1'b0);
      step(1'b0);
      chk("reset_q", int'(q4), 0);
      chk("reset_tc", int'(tc4), 0);

      // Release for 20 edges: 1..15, 0, 1..4
      for (int k = 1; k <= 20; k++) begin
         step(1'b1);
         chk("seq_q", int'(q4), k % 16);
         chk("seq_wrap", int'(wrap4), (k == 16) ? 1 : 0);
      end
      chk("seq_wc_end", int'(wc4), 1);

      // Mid-count reset at q=7
      for (int k = 0; k < 3; k++) step(1'b1);
      chk("mid_pre_q", int'(q4), 7);
      step(1'b0);
      chk("mid_q", int'(q4), 0);
      chk("mid_wrap", int'(wrap4), 0);
      chk("mid_wc", int'(wc4), 0);
      step(1'b1);
      chk("mid_release_q", int'(q4), 1);

      // Reset exactly at the edge where q=15
      for (int k = 0; k < 14; k++) step(1'b1);
      chk("tcrst_pre_q", int'(q4), 15);
      chk("tcrst_pre_tc", int'(tc4), 1);
      step(1'b0);
      chk("tcrst_q", int'(q4), 0);
      chk("tcrst_wrap", int'(wrap4), 0);
      chk("tcrst_wc", int'(wc4), 0);

      // Long run: 16*260 edges, wrap_cnt saturates, wrap keeps pulsing
      wrap_edges = 0;
      for (int k = 0; k < 16 * 260; k++) begin
         step(1'b1);
         if (wrap4 === 1'b1) wrap_edges++;
      end
      chk("long_wc4", int'(wc4), 255);
      chk("long_wc3", int'(wc3), 255);
      chk("long_wrap_count", wrap_edges, 260);
      chk("long_q_end", int'(q4), 0);
      chk("long_wrap_end", int'(wrap4), 1);

      // Reassert reset for toggle coverage
      step(1'b0);
      step(1'b0);
      chk("final_q", int'(q4), 0);
      chk("final_wc", int'(wc4), 0);
      for (int unsigned i = 0; i < 8; i++) begin
         chk($sformatf("toggle_%0d", i), int'(seen0[i] & seen1[i]), 1);
      end
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
